// File: rtl/clk_sel_ctrl.sv
// Clock-select controller for a glitch-free clock mux: handshaked software switches,
// health-filtered automatic failover, and a fixed settle window after every sel change.
module clk_sel_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int FAIL_FILT  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic clk0_ok,
    input  logic clk1_ok,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err,
    output logic failover,
    output logic no_clk
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int FW = $clog2(FAIL_FILT + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
    localparam logic [FW-1:0] FAIL_MAX    = FW'(FAIL_FILT);

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic            sel_reg, sel_next;
    logic [SW-1:0]   settle_cnt_reg, settle_cnt_next;
    logic [FW-1:0]   fail_cnt_reg, fail_cnt_next;
    logic            done_reg, done_next;
    logic            err_reg, err_next;
    logic            failover_reg, failover_next;
    logic            no_clk_reg, no_clk_next;

    logic            active_ok;
    logic            other_ok;
    logic            target_ok;
    logic            in_run;
    logic            fail_hit;
    logic            failover_cond;
    logic            switch_go;

    assign active_ok     = sel_reg ? clk1_ok : clk0_ok;
    assign other_ok      = sel_reg ? clk0_ok : clk1_ok;
    assign target_ok     = req_sel ? clk1_ok : clk0_ok;
    assign in_run        = (state_reg == RUN);
    assign fail_hit      = (fail_cnt_reg == FAIL_MAX);
    assign failover_cond = in_run & fail_hit & other_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            sel_reg        <= 1'b0;
            settle_cnt_reg <= '0;
            fail_cnt_reg   <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            failover_reg   <= 1'b0;
            no_clk_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            settle_cnt_reg <= settle_cnt_next;
            fail_cnt_reg   <= fail_cnt_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            failover_reg   <= failover_next;
            no_clk_reg     <= no_clk_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        settle_cnt_next = settle_cnt_reg;
        fail_cnt_next   = fail_cnt_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        failover_next   = 1'b0;
        switch_go       = 1'b0;

        case (state_reg)
            RUN: begin
                // Failover wins over a request; that request stays pending.
                if (failover_cond) begin
                    sel_next      = ~sel_reg;
                    failover_next = 1'b1;
                    switch_go     = 1'b1;
                end else begin
                    if (active_ok) begin
                        fail_cnt_next = '0;
                    end else if (!fail_hit) begin
                        fail_cnt_next = fail_cnt_reg + FW'(1);
                    end
                    if (req_valid) begin
                        if (req_sel == sel_reg) begin
                            done_next = 1'b1;
                        end else if (!target_ok) begin
                            err_next = 1'b1;
                        end else begin
                            sel_next  = req_sel;
                            switch_go = 1'b1;
                        end
                    end
                end
                if (switch_go) begin
                    state_next      = SETTLE;
                    settle_cnt_next = SETTLE_LOAD;
                    fail_cnt_next   = '0;
                end
            end
            SETTLE: begin
                fail_cnt_next = '0;
                if (settle_cnt_reg == '0) begin
                    state_next = RUN;
                    done_next  = 1'b1;
                end else begin
                    settle_cnt_next = settle_cnt_reg - SW'(1);
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        // Stranded: still on a dead source with nowhere healthy to go.
        no_clk_next = (state_next == RUN) && (fail_cnt_next == FAIL_MAX) && !other_ok;
    end

    always_comb begin
        req_ready = ~rst & in_run & ~failover_cond;
        busy      = (state_reg == SETTLE);
        sel       = sel_reg;
        done      = done_reg;
        err       = err_reg;
        failover  = failover_reg;
        no_clk    = no_clk_reg;
    end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed plus randomized bench for clk_sel_ctrl, checked against a timeline-based
// reference model (cycles since last switch, length of the current bad streak).
module tb_clk_sel_ctrl;

    localparam int SETTLE_CYC = 16;
    localparam int FAIL_FILT  = 4;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic clk0_ok;
    logic clk1_ok;
    logic sel;
    logic busy;
    logic done;
    logic err;
    logic failover;
    logic no_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_sel;
    int m_since;
    int m_streak;
    bit m_done, m_err, m_fo, m_noclk;

    clk_sel_ctrl #(
        .SETTLE_CYC(SETTLE_CYC),
        .FAIL_FILT (FAIL_FILT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .clk0_ok  (clk0_ok),
        .clk1_ok  (clk1_ok),
        .sel      (sel),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .failover (failover),
        .no_clk   (no_clk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b (check %0d)", tag, obs, exp, checks);
        end
    endtask

    function automatic bit m_busy();
        return m_since < SETTLE_CYC;
    endfunction

    function automatic bit m_fo_cond(input bit ok0, input bit ok1);
        bit oth;
        oth = m_sel ? ok0 : ok1;
        return !m_busy() && (m_streak >= FAIL_FILT) && oth;
    endfunction

    task automatic model_reset();
        m_sel    = 1'b0;
        m_since  = SETTLE_CYC;
        m_streak = 0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_fo     = 1'b0;
        m_noclk  = 1'b0;
    endtask

    task automatic model_edge(input bit rv, input bit rs, input bit ok0, input bit ok1);
        bit act, oth, tgt, fo;
        act = m_sel ? ok1 : ok0;
        tgt = rs ? ok1 : ok0;
        fo  = m_fo_cond(ok0, ok1);
        m_done = 1'b0;
        m_err  = 1'b0;
        m_fo   = 1'b0;
        if (m_busy()) begin
            m_since++;
            m_streak = 0;
            if (m_since == SETTLE_CYC) m_done = 1'b1;
        end else if (fo) begin
            m_sel    = ~m_sel;
            m_since  = 0;
            m_streak = 0;
            m_fo     = 1'b1;
        end else begin
            m_streak = act ? 0 : m_streak + 1;
            if (rv) begin
                if (rs == m_sel) m_done = 1'b1;
                else if (!tgt) m_err = 1'b1;
                else begin
                    m_sel    = rs;
                    m_since  = 0;
                    m_streak = 0;
                end
            end
        end
        oth     = m_sel ? ok0 : ok1;
        m_noclk = !m_busy() && (m_streak >= FAIL_FILT) && !oth;
    endtask

    task automatic step(input bit rv, input bit rs, input bit ok0, input bit ok1);
        @(negedge clk);
        req_valid = rv;
        req_sel   = rs;
        clk0_ok   = ok0;
        clk1_ok   = ok1;
        #1;
        chk("req_ready", req_ready, !m_busy() && !m_fo_cond(ok0, ok1));
        @(posedge clk);
        model_edge(rv, rs, ok0, ok1);
        #1;
        chk("sel", sel, m_sel);
        chk("busy", busy, m_busy());
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("failover", failover, m_fo);
        chk("no_clk", no_clk, m_noclk);
        $display("t=%0t rv=%b rs=%b ok=%b%b -> sel=%b busy=%b done=%b err=%b fo=%b no_clk=%b",
                 $time, rv, rs, ok1, ok0, sel, busy, done, err, failover, no_clk);
    endtask

    task automatic idle(input int n, input bit ok0, input bit ok1);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, ok0, ok1);
    endtask

    initial begin
        bit r0, r1;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 1'b0;
        clk0_ok   = 1'b1;
        clk1_ok   = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_sel", sel, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_no_clk", no_clk, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1'b1);

        // Software switch to clk1 and full settle window
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("accept_sel", sel, 1'b1);
        chk("accept_busy", busy, 1'b1);
        idle(SETTLE_CYC - 1, 1'b1, 1'b1);
        chk("pre_done_busy", busy, 1'b1);
        idle(1, 1'b1, 1'b1);
        chk("settle_done", done, 1'b1);
        chk("settle_busy_off", busy, 1'b0);

        // No-op then reject
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("noop_done", done, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reject_err", err, 1'b1);
        chk("reject_sel", sel, 1'b1);

        // Back to clk0
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(SETTLE_CYC + 1, 1'b1, 1'b1);

        // Short dropout: no failover
        idle(3, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b1);
        chk("short_drop_sel", sel, 1'b0);

        // Sustained dropout: failover on the edge after the counter saturates
        idle(FAIL_FILT, 1'b0, 1'b1);
        chk("pre_failover_sel", sel, 1'b0);
        idle(1, 1'b0, 1'b1);
        chk("failover_pulse", failover, 1'b1);
        chk("failover_sel", sel, 1'b1);
        idle(SETTLE_CYC + 2, 1'b1, 1'b1);

        // Return to clk0, then both sources dead
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(SETTLE_CYC + 1, 1'b1, 1'b1);
        idle(FAIL_FILT + 2, 1'b0, 1'b0);
        chk("no_clk_level", no_clk, 1'b1);
        chk("no_clk_sel", sel, 1'b0);
        idle(1, 1'b0, 1'b1);
        chk("no_clk_clear", no_clk, 1'b0);
        chk("recover_failover", failover, 1'b1);
        idle(SETTLE_CYC + 1, 1'b1, 1'b1);

        // Failover and request in the same cycle; request stays pending
        idle(FAIL_FILT, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("collide_failover", failover, 1'b1);
        chk("collide_sel", sel, 1'b0);
        for (int i = 0; i < SETTLE_CYC; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("pending_accept_sel", sel, 1'b1);
        idle(SETTLE_CYC + 1, 1'b1, 1'b1);

        // Reset five cycles into a settle toward clk1
        step(1'b1, 1'b0, 1'b1, 1'b1);
        idle(SETTLE_CYC + 1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        idle(5, 1'b1, 1'b1);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("midrst_ready_comb", req_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_sel", sel, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", req_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(2, 1'b1, 1'b1);

        // Randomized traffic with wandering health flags
        r0 = 1'b1;
        r1 = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(11) == 0) r0 = ~r0;
            if ($urandom_range(11) == 0) r1 = ~r1;
            step($urandom_range(3) == 0, 1'($urandom_range(1)), r0, r1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
